// File: rtl/tl_arb_pkg.sv
// Shared TileLink-UL A-channel arbitration types, constants and burst-length helper.
package tl_arb_pkg;

  localparam int unsigned BEAT_BYTES = 4;
  localparam int unsigned BEATS_W    = 16;

  localparam logic [2:0] TL_A_PUTFULL    = 3'd0;
  localparam logic [2:0] TL_A_PUTPARTIAL = 3'd1;

  // Master-side A payload; source excludes the port index the arbiter prepends.
  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [3:0]  size;
    logic [5:0]  source;
    logic [29:0] address;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        corrupt;
  } tl_a_req_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Only multi-beat puts carry data across more than one beat.
  function automatic logic [BEATS_W-1:0] tl_num_beats(input logic [2:0] opcode,
                                                      input logic [3:0] size);
    logic [BEATS_W-1:0] beats;
    beats = BEATS_W'(1);
    if ((opcode == TL_A_PUTFULL || opcode == TL_A_PUTPARTIAL) && size > 4'd2)
      beats = BEATS_W'((32'd1 << size) / BEAT_BYTES);
    return beats;
  endfunction

endpackage

// File: rtl/tl_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the requester that was not last wins.
module tl_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       sel,
  output logic       any
);

  assign any = |req;
  assign sel = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/tl_a_arbiter_2to1.sv
// Two-master TileLink-UL arbiter: round-robin A channel with burst lock, D routed by source MSB.
module tl_a_arbiter_2to1
  import tl_arb_pkg::*;
#(
  parameter int unsigned MAX_LGSIZE = 6,
  parameter int unsigned BEAT_CNT_W = 4
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        m0_a_valid,
  output logic        m0_a_ready,
  input  logic [2:0]  m0_a_opcode,
  input  logic [2:0]  m0_a_param,
  input  logic [3:0]  m0_a_size,
  input  logic [5:0]  m0_a_source,
  input  logic [29:0] m0_a_address,
  input  logic [3:0]  m0_a_mask,
  input  logic [31:0] m0_a_data,
  input  logic        m0_a_corrupt,

  input  logic        m1_a_valid,
  output logic        m1_a_ready,
  input  logic [2:0]  m1_a_opcode,
  input  logic [2:0]  m1_a_param,
  input  logic [3:0]  m1_a_size,
  input  logic [5:0]  m1_a_source,
  input  logic [29:0] m1_a_address,
  input  logic [3:0]  m1_a_mask,
  input  logic [31:0] m1_a_data,
  input  logic        m1_a_corrupt,

  output logic        s_a_valid,
  input  logic        s_a_ready,
  output logic [2:0]  s_a_opcode,
  output logic [2:0]  s_a_param,
  output logic [3:0]  s_a_size,
  output logic [6:0]  s_a_source,
  output logic [29:0] s_a_address,
  output logic [3:0]  s_a_mask,
  output logic [31:0] s_a_data,
  output logic        s_a_corrupt,

  input  logic        s_d_valid,
  output logic        s_d_ready,
  input  logic [2:0]  s_d_opcode,
  input  logic [1:0]  s_d_param,
  input  logic [3:0]  s_d_size,
  input  logic [6:0]  s_d_source,
  input  logic        s_d_denied,
  input  logic [31:0] s_d_data,
  input  logic        s_d_corrupt,

  output logic        m0_d_valid,
  input  logic        m0_d_ready,
  output logic [2:0]  m0_d_opcode,
  output logic [1:0]  m0_d_param,
  output logic [3:0]  m0_d_size,
  output logic [5:0]  m0_d_source,
  output logic        m0_d_denied,
  output logic [31:0] m0_d_data,
  output logic        m0_d_corrupt,

  output logic        m1_d_valid,
  input  logic        m1_d_ready,
  output logic [2:0]  m1_d_opcode,
  output logic [1:0]  m1_d_param,
  output logic [3:0]  m1_d_size,
  output logic [5:0]  m1_d_source,
  output logic        m1_d_denied,
  output logic [31:0] m1_d_data,
  output logic        m1_d_corrupt
);

  arb_state_t            state_q, state_d;
  logic                  owner_q, owner_d;
  logic [BEAT_CNT_W-1:0] beats_left_q, beats_left_d;
  logic                  rr_last_q, rr_last_d;

  tl_a_req_t             m0_req, m1_req, a_req;
  logic                  pick_sel, pick_any;
  logic                  grant, grant_valid, grant_ok, fire;
  logic [3:0]            eff_size;
  logic [BEATS_W-1:0]    burst_beats;

  assign m0_req = {m0_a_opcode, m0_a_param, m0_a_size, m0_a_source,
                   m0_a_address, m0_a_mask, m0_a_data, m0_a_corrupt};
  assign m1_req = {m1_a_opcode, m1_a_param, m1_a_size, m1_a_source,
                   m1_a_address, m1_a_mask, m1_a_data, m1_a_corrupt};

  tl_rr_pick2 u_pick (
    .req  ({m1_a_valid, m0_a_valid}),
    .last (rr_last_q),
    .sel  (pick_sel),
    .any  (pick_any)
  );

  // State register; a reset mid-burst simply drops the lock.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      owner_q      <= 1'b0;
      beats_left_q <= '0;
      rr_last_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      beats_left_q <= beats_left_d;
      rr_last_q    <= rr_last_d;
    end
  end

  // Grant mux, A handshake and next-state logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    beats_left_d = beats_left_q;
    rr_last_d    = rr_last_q;

    grant       = (state_q == ARB_LOCKED) ? owner_q : pick_sel;
    grant_ok    = (state_q == ARB_LOCKED) || pick_any;
    a_req       = grant ? m1_req : m0_req;
    grant_valid = grant ? m1_a_valid : m0_a_valid;

    s_a_valid  = ~reset & grant_valid;
    m0_a_ready = ~reset & grant_ok & ~grant & s_a_ready;
    m1_a_ready = ~reset & grant_ok &  grant & s_a_ready;
    fire       = s_a_valid & s_a_ready;

    // Oversized requests are illegal; clamping just keeps the count bounded.
    eff_size    = (32'(a_req.size) > MAX_LGSIZE) ? 4'(MAX_LGSIZE) : a_req.size;
    burst_beats = tl_num_beats(a_req.opcode, eff_size);

    unique case (state_q)
      ARB_IDLE: begin
        if (fire) begin
          if (burst_beats > BEATS_W'(1)) begin
            state_d      = ARB_LOCKED;
            owner_d      = grant;
            beats_left_d = BEAT_CNT_W'(burst_beats - BEATS_W'(1));
          end else begin
            rr_last_d = grant;
          end
        end
      end
      ARB_LOCKED: begin
        if (fire) begin
          beats_left_d = beats_left_q - BEAT_CNT_W'(1);
          if (beats_left_q == BEAT_CNT_W'(1)) begin
            state_d   = ARB_IDLE;
            rr_last_d = owner_q;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign s_a_opcode  = a_req.opcode;
  assign s_a_param   = a_req.param;
  assign s_a_size    = a_req.size;
  assign s_a_source  = {grant, a_req.source};
  assign s_a_address = a_req.address;
  assign s_a_mask    = a_req.mask;
  assign s_a_data    = a_req.data;
  assign s_a_corrupt = a_req.corrupt;

  // D channel: stateless steer on the prepended port bit.
  assign m0_d_valid = ~reset & s_d_valid & ~s_d_source[6];
  assign m1_d_valid = ~reset & s_d_valid &  s_d_source[6];
  assign s_d_ready  = ~reset & (s_d_source[6] ? m1_d_ready : m0_d_ready);

  assign m0_d_opcode  = s_d_opcode;
  assign m0_d_param   = s_d_param;
  assign m0_d_size    = s_d_size;
  assign m0_d_source  = s_d_source[5:0];
  assign m0_d_denied  = s_d_denied;
  assign m0_d_data    = s_d_data;
  assign m0_d_corrupt = s_d_corrupt;

  assign m1_d_opcode  = s_d_opcode;
  assign m1_d_param   = s_d_param;
  assign m1_d_size    = s_d_size;
  assign m1_d_source  = s_d_source[5:0];
  assign m1_d_denied  = s_d_denied;
  assign m1_d_data    = s_d_data;
  assign m1_d_corrupt = s_d_corrupt;

endmodule

// File: tb/tb_tl_a_arbiter_2to1.sv
// Bench for tl_a_arbiter_2to1: directed scenarios plus random traffic against a transaction-level model.
module tb_tl_a_arbiter_2to1;

  logic        clock = 1'b0;
  logic        reset;

  logic        m0_a_valid, m0_a_ready, m1_a_valid, m1_a_ready;
  logic [2:0]  m0_a_opcode, m0_a_param, m1_a_opcode, m1_a_param;
  logic [3:0]  m0_a_size, m0_a_mask, m1_a_size, m1_a_mask;
  logic [5:0]  m0_a_source, m1_a_source;
  logic [29:0] m0_a_address, m1_a_address;
  logic [31:0] m0_a_data, m1_a_data;
  logic        m0_a_corrupt, m1_a_corrupt;

  logic        s_a_valid, s_a_ready;
  logic [2:0]  s_a_opcode, s_a_param;
  logic [3:0]  s_a_size, s_a_mask;
  logic [6:0]  s_a_source;
  logic [29:0] s_a_address;
  logic [31:0] s_a_data;
  logic        s_a_corrupt;

  logic        s_d_valid, s_d_ready;
  logic [2:0]  s_d_opcode;
  logic [1:0]  s_d_param;
  logic [3:0]  s_d_size;
  logic [6:0]  s_d_source;
  logic        s_d_denied, s_d_corrupt;
  logic [31:0] s_d_data;

  logic        m0_d_valid, m0_d_ready, m1_d_valid, m1_d_ready;
  logic [2:0]  m0_d_opcode, m1_d_opcode;
  logic [1:0]  m0_d_param, m1_d_param;
  logic [3:0]  m0_d_size, m1_d_size;
  logic [5:0]  m0_d_source, m1_d_source;
  logic        m0_d_denied, m1_d_denied, m0_d_corrupt, m1_d_corrupt;
  logic [31:0] m0_d_data, m1_d_data;

  always #5 clock = ~clock;

  tl_a_arbiter_2to1 #(.MAX_LGSIZE(6), .BEAT_CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_opcode(m0_a_opcode),
    .m0_a_param(m0_a_param), .m0_a_size(m0_a_size), .m0_a_source(m0_a_source),
    .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data),
    .m0_a_corrupt(m0_a_corrupt),
    .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_opcode(m1_a_opcode),
    .m1_a_param(m1_a_param), .m1_a_size(m1_a_size), .m1_a_source(m1_a_source),
    .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data),
    .m1_a_corrupt(m1_a_corrupt),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
    .s_a_param(s_a_param), .s_a_size(s_a_size), .s_a_source(s_a_source),
    .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
    .s_a_corrupt(s_a_corrupt),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
    .s_d_param(s_d_param), .s_d_size(s_d_size), .s_d_source(s_d_source),
    .s_d_denied(s_d_denied), .s_d_data(s_d_data), .s_d_corrupt(s_d_corrupt),
    .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready), .m0_d_opcode(m0_d_opcode),
    .m0_d_param(m0_d_param), .m0_d_size(m0_d_size), .m0_d_source(m0_d_source),
    .m0_d_denied(m0_d_denied), .m0_d_data(m0_d_data), .m0_d_corrupt(m0_d_corrupt),
    .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready), .m1_d_opcode(m1_d_opcode),
    .m1_d_param(m1_d_param), .m1_d_size(m1_d_size), .m1_d_source(m1_d_source),
    .m1_d_denied(m1_d_denied), .m1_d_data(m1_d_data), .m1_d_corrupt(m1_d_corrupt)
  );

  // Sizes above MAX_LGSIZE are illegal stimulus.
  always @(posedge clock) begin
    if (!reset && m0_a_valid) assert (m0_a_size <= 4'd6);
    if (!reset && m1_a_valid) assert (m1_a_size <= 4'd6);
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level model: burst owner with remaining beat count, and last master served.
  int burst_rem = 0;
  int burst_who = 0;
  int last_served = 1;
  int seen_grant;

  function automatic int beats_of(input int opc, input int size);
    if ((opc == 0 || opc == 1) && size > 2) return (1 << size) / 4;
    return 1;
  endfunction

  task automatic drive_a(input int m, input bit v, input int opc, input int size, input int src);
    if (m == 0) begin
      m0_a_valid = v; m0_a_opcode = 3'(opc); m0_a_size = 4'(size); m0_a_source = 6'(src);
      m0_a_param = 3'($urandom); m0_a_address = 30'($urandom); m0_a_mask = 4'($urandom);
      m0_a_data = $urandom; m0_a_corrupt = 1'($urandom);
    end else begin
      m1_a_valid = v; m1_a_opcode = 3'(opc); m1_a_size = 4'(size); m1_a_source = 6'(src);
      m1_a_param = 3'($urandom); m1_a_address = 30'($urandom); m1_a_mask = 4'($urandom);
      m1_a_data = $urandom; m1_a_corrupt = 1'($urandom);
    end
  endtask

  task automatic drive_d(input bit v, input int src, input bit r0, input bit r1);
    s_d_valid = v; s_d_source = 7'(src); m0_d_ready = r0; m1_d_ready = r1;
    s_d_opcode = 3'($urandom); s_d_param = 2'($urandom); s_d_size = 4'($urandom);
    s_d_denied = 1'($urandom); s_d_data = $urandom; s_d_corrupt = 1'($urandom);
  endtask

  // Check every output against the model for the current inputs, then advance one clock.
  task automatic step();
    int g;
    bit v, fire, ds;
    fire = 1'b0;
    g = 0;
    #1;
    if (reset) begin
      check("rst_s_a_valid", s_a_valid, 0);
      check("rst_m0_a_ready", m0_a_ready, 0);
      check("rst_m1_a_ready", m1_a_ready, 0);
      check("rst_s_d_ready", s_d_ready, 0);
      check("rst_m0_d_valid", m0_d_valid, 0);
      check("rst_m1_d_valid", m1_d_valid, 0);
    end else begin
      if (burst_rem > 0) g = burst_who;
      else if (m0_a_valid && m1_a_valid) g = 1 - last_served;
      else g = m1_a_valid ? 1 : 0;
      v = (g == 1) ? m1_a_valid : m0_a_valid;
      check("s_a_valid", s_a_valid, v);
      if (v || burst_rem > 0) begin
        check("m0_a_ready", m0_a_ready, (g == 0) && s_a_ready);
        check("m1_a_ready", m1_a_ready, (g == 1) && s_a_ready);
      end
      if (v) begin
        check("s_a_source", s_a_source, {g[0], (g == 1) ? m1_a_source : m0_a_source});
        check("s_a_address", s_a_address, (g == 1) ? m1_a_address : m0_a_address);
        check("s_a_data", s_a_data, (g == 1) ? m1_a_data : m0_a_data);
        check("s_a_opcode", s_a_opcode, (g == 1) ? m1_a_opcode : m0_a_opcode);
      end
      ds = s_d_source[6];
      check("m0_d_valid", m0_d_valid, s_d_valid && !ds);
      check("m1_d_valid", m1_d_valid, s_d_valid && ds);
      check("s_d_ready", s_d_ready, ds ? m1_d_ready : m0_d_ready);
      check("m1_d_source", m1_d_source, s_d_source[5:0]);
      check("m0_d_data", m0_d_data, s_d_data);
      fire = v && s_a_ready;
    end
    @(posedge clock);
    if (reset) begin
      burst_rem = 0; last_served = 1;
    end else if (fire) begin
      if (burst_rem > 0) begin
        burst_rem--;
        if (burst_rem == 0) last_served = burst_who;
      end else begin
        int n;
        n = (g == 1) ? beats_of(m1_a_opcode, m1_a_size) : beats_of(m0_a_opcode, m0_a_size);
        if (n > 1) begin burst_rem = n - 1; burst_who = g; end
        else last_served = g;
      end
    end
    seen_grant = fire ? g : -1;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    s_a_ready = 1'b1;
    drive_a(0, 1, 4, 2, 1);
    drive_a(1, 1, 4, 2, 2);
    drive_d(1, 'h05, 1, 1);
    repeat (2) step();
    reset = 1'b0;

    // Round-robin tie from reset: m0, m1, m0, m1.
    for (int i = 0; i < 4; i++) begin
      drive_a(0, 1, 4, 2, i);
      drive_a(1, 1, 4, 2, i + 8);
      drive_d(0, 0, 1, 1);
      #1;
      check("rr_src_msb", s_a_source[6], i % 2);
      step();
      check("rr_grant", seen_grant, i % 2);
    end

    // Single beat from m0 alone, with a D response to m0 in the same cycle.
    drive_a(0, 1, 4, 2, 'h05);
    drive_a(1, 0, 4, 2, 0);
    drive_d(1, 'h05, 1, 1);
    #1;
    check("single_src", s_a_source, 7'h05);
    check("single_valid", s_a_valid, 1);
    check("d_m0_valid", m0_d_valid, 1);
    check("d_m1_valid", m1_d_valid, 0);
    step();

    // Burst lock: m1 4-beat PutFull beats m0 (last served m0), m0 waits.
    drive_d(0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      drive_a(0, 1, 4, 2, 3);
      drive_a(1, (i == 0) ? 1'b1 : 1'b1, 0, 4, 9);
      #1;
      check("lock_m0_ready", m0_a_ready, 0);
      step();
      check("lock_m1_fire", seen_grant, 1);
    end
    drive_a(1, 1, 4, 2, 9);
    #1;
    check("post_lock_m0", m0_a_ready, 1);
    step();
    check("post_lock_grant", seen_grant, 0);

    // Backpressure mid-burst: 2-beat PutFull from m0, slave stalls 3 cycles.
    drive_a(0, 1, 0, 3, 4);
    drive_a(1, 0, 4, 2, 0);
    step();
    check("bp_beat1", seen_grant, 0);
    s_a_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_a(1, 1, 4, 2, 7);
      #1;
      check("bp_hold_valid", s_a_valid, 1);
      check("bp_m1_ready", m1_a_ready, 0);
      step();
    end
    s_a_ready = 1'b1;
    step();
    check("bp_beat2", seen_grant, 0);
    drive_a(0, 1, 4, 2, 4);
    step();
    check("bp_then_m1", seen_grant, 1);

    // D routing with a stalled master 1.
    drive_d(1, 'h47, 1, 0);
    #1;
    check("dstall_m1_valid", m1_d_valid, 1);
    check("dstall_m1_src", m1_d_source, 6'h07);
    check("dstall_ready", s_d_ready, 0);
    check("dstall_m0_valid", m0_d_valid, 0);
    step();

    // Reset after beat 2 of a 4-beat burst, then a tie goes to m0.
    drive_d(0, 0, 1, 1);
    drive_a(1, 0, 4, 2, 0);
    drive_a(0, 1, 0, 4, 6);
    repeat (2) step();
    reset = 1'b1;
    drive_a(1, 1, 4, 2, 1);
    drive_d(1, 'h41, 1, 1);
    repeat (2) step();
    reset = 1'b0;
    drive_a(0, 1, 4, 2, 2);
    drive_a(1, 1, 4, 2, 3);
    drive_d(0, 0, 1, 1);
    #1;
    check("post_rst_m0_ready", m0_a_ready, 1);
    check("post_rst_src_msb", s_a_source[6], 0);
    step();
    check("post_rst_grant", seen_grant, 0);

    // Random traffic, including master stalls mid-burst and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      int opc;
      opc = ($urandom_range(0, 3) == 0) ? 4 : $urandom_range(0, 1);
      drive_a(0, $urandom_range(0, 9) < 7, opc, $urandom_range(0, 6), $urandom);
      opc = ($urandom_range(0, 3) == 0) ? 4 : $urandom_range(0, 1);
      drive_a(1, $urandom_range(0, 9) < 7, opc, $urandom_range(0, 6), $urandom);
      drive_d($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom_range(0, 1));
      s_a_ready = $urandom_range(0, 3) != 0;
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
